// File: rtl/rob_multi_commit.sv
// Reorder buffer: one dispatch and one writeback per cycle; up to COMMIT_W in-order retirements per cycle.
// A retiring mispredicted branch flushes at the edge; disp_ready is low when full or flushing.
module rob_multi_commit #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = 4,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32,
  parameter int AREG_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_valid,
  input  logic [1:0]                 disp_type,
  input  logic [AREG_W-1:0]          disp_dest,
  output logic                       disp_ready,
  output logic [TAG_W-1:0]           disp_tag,
  input  logic                       wb_valid,
  input  logic [TAG_W-1:0]           wb_tag,
  input  logic [DATA_W-1:0]          wb_value,
  input  logic [AREG_W-1:0]          wb_addr,
  input  logic                       wb_mispredict,
  input  logic [31:0]                wb_target,
  input  logic [TAG_W-1:0]           rd_tag1,
  input  logic [TAG_W-1:0]           rd_tag2,
  output logic                       rd_ready1,
  output logic                       rd_ready2,
  output logic [DATA_W-1:0]          rd_value1,
  output logic [DATA_W-1:0]          rd_value2,
  output logic [COMMIT_W-1:0]        cmt_valid,
  output logic [2*COMMIT_W-1:0]      cmt_type,
  output logic [AREG_W*COMMIT_W-1:0] cmt_dest,
  output logic [DATA_W*COMMIT_W-1:0] cmt_value,
  output logic                       flush,
  output logic [31:0]                flush_pc,
  output logic [TAG_W:0]             count,
  output logic                       full
);

  localparam logic [1:0]     T_STORE   = 2'd2;
  localparam logic [1:0]     T_BRANCH  = 2'd3;
  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] CNT_ONE   = (TAG_W+1)'(1);

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [1:0]        typ;
    logic [AREG_W-1:0] dest;
    logic [DATA_W-1:0] value;
    logic              mispredict;
    logic [31:0]       target;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W-1:0] head_new;
  logic [TAG_W-1:0] cmt_idx;
  logic [TAG_W:0]   n_cmt;
  logic             cmt_stop;
  logic             disp_fire;
  logic             rd_hit1;
  logic             rd_hit2;

  assign full       = (count == DEPTH_CNT);
  assign disp_ready = (count < DEPTH_CNT) && !flush;
  assign disp_tag   = tail;
  assign disp_fire  = disp_valid && disp_ready;
  assign head_new   = head + n_cmt[TAG_W-1:0];

  // Same-cycle writeback is forwarded so a consumer can issue without waiting an extra cycle.
  assign rd_hit1   = wb_valid && (wb_tag == rd_tag1) && ent[rd_tag1].valid;
  assign rd_hit2   = wb_valid && (wb_tag == rd_tag2) && ent[rd_tag2].valid;
  assign rd_ready1 = (ent[rd_tag1].valid && ent[rd_tag1].ready) || rd_hit1;
  assign rd_ready2 = (ent[rd_tag2].valid && ent[rd_tag2].ready) || rd_hit2;
  assign rd_value1 = rd_hit1 ? wb_value : ent[rd_tag1].value;
  assign rd_value2 = rd_hit2 ? wb_value : ent[rd_tag2].value;

  // Retire a contiguous prefix; a store or a mispredicted branch closes the group.
  always_comb begin
    cmt_valid = '0;
    cmt_type  = '0;
    cmt_dest  = '0;
    cmt_value = '0;
    n_cmt     = '0;
    flush     = 1'b0;
    flush_pc  = '0;
    cmt_stop  = 1'b0;
    cmt_idx   = head;
    for (int i = 0; i < COMMIT_W; i++) begin
      cmt_idx = head + TAG_W'(i);
      if (!cmt_stop && ent[cmt_idx].valid && ent[cmt_idx].ready) begin
        cmt_valid[i]                  = 1'b1;
        n_cmt                         = n_cmt + CNT_ONE;
        cmt_type[2*i +: 2]            = ent[cmt_idx].typ;
        cmt_dest[AREG_W*i +: AREG_W]  = ent[cmt_idx].dest;
        cmt_value[DATA_W*i +: DATA_W] = ent[cmt_idx].value;
        if (ent[cmt_idx].typ == T_STORE) begin
          cmt_stop = 1'b1;
        end
        if (ent[cmt_idx].typ == T_BRANCH && ent[cmt_idx].mispredict) begin
          cmt_stop = 1'b1;
          flush    = 1'b1;
          flush_pc = ent[cmt_idx].target;
        end
      end else begin
        cmt_stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else if (flush) begin
      // Everything younger than the branch is squashed; the buffer restarts empty at head_new.
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].ready <= 1'b0;
      end
      head  <= head_new;
      tail  <= head_new;
      count <= '0;
    end else begin
      if (wb_valid && ent[wb_tag].valid) begin
        ent[wb_tag].ready <= 1'b1;
        ent[wb_tag].value <= wb_value;
        if (ent[wb_tag].typ == T_STORE) begin
          ent[wb_tag].dest <= wb_addr;
        end
        if (ent[wb_tag].typ == T_BRANCH) begin
          ent[wb_tag].mispredict <= wb_mispredict;
          ent[wb_tag].target     <= wb_target;
        end
      end
      for (int i = 0; i < COMMIT_W; i++) begin
        if (cmt_valid[i]) begin
          ent[head + TAG_W'(i)].valid <= 1'b0;
          ent[head + TAG_W'(i)].ready <= 1'b0;
        end
      end
      if (disp_fire) begin
        ent[tail].valid      <= 1'b1;
        ent[tail].ready      <= 1'b0;
        ent[tail].typ        <= disp_type;
        ent[tail].dest       <= disp_dest;
        ent[tail].mispredict <= 1'b0;
      end
      head  <= head_new;
      tail  <= tail + TAG_W'(disp_fire);
      count <= count + (TAG_W+1)'(disp_fire) - n_cmt;
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: directed vector tables, hand sequences for flush/reset, random traffic vs a queue model.
module tb_rob_multi_commit;
  localparam int DEPTH = 16;
  localparam int CW    = 2;
  localparam logic [1:0] T_ST = 2'd2;
  localparam logic [1:0] T_BR = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_valid, disp_ready;
  logic [1:0]  disp_type;
  logic [6:0]  disp_dest;
  logic [3:0]  disp_tag;
  logic        wb_valid, wb_mispredict;
  logic [3:0]  wb_tag;
  logic [31:0] wb_value, wb_target;
  logic [6:0]  wb_addr;
  logic [3:0]  rd_tag1, rd_tag2;
  logic        rd_ready1, rd_ready2;
  logic [31:0] rd_value1, rd_value2;
  logic [1:0]  cmt_valid;
  logic [3:0]  cmt_type;
  logic [13:0] cmt_dest;
  logic [63:0] cmt_value;
  logic        flush;
  logic [31:0] flush_pc;
  logic [4:0]  count;
  logic        full;

  rob_multi_commit dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_type(disp_type), .disp_dest(disp_dest),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_addr(wb_addr),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .rd_tag1(rd_tag1), .rd_tag2(rd_tag2), .rd_ready1(rd_ready1), .rd_ready2(rd_ready2),
    .rd_value1(rd_value1), .rd_value2(rd_value2),
    .cmt_valid(cmt_valid), .cmt_type(cmt_type), .cmt_dest(cmt_dest), .cmt_value(cmt_value),
    .flush(flush), .flush_pc(flush_pc), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic dv; logic [1:0] dt; logic [6:0] dd;
    logic wv; logic [3:0] wt; logic [31:0] wval; logic [6:0] wa;
    logic [3:0] rt;
    logic e_rdy; logic [3:0] e_tag; logic [4:0] e_cnt;
    logic [1:0] e_cv; logic [3:0] e_ctype; logic [13:0] e_cdest; logic [63:0] e_cval;
    logic e_rr; logic [31:0] e_rv;
  } vec_t;

  typedef struct {
    logic [3:0] tag; logic [1:0] typ; logic [6:0] dest;
    logic rdy; logic [31:0] val; logic mis; logic [31:0] tgt;
  } mrec_t;

  mrec_t mq[$];
  int    m_tail;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_slot(input string nm, input int k, input logic [1:0] t,
                          input logic [6:0] d, input logic [31:0] v);
    chk($sformatf("%s.type%0d", nm, k), 64'(cmt_type[2*k +: 2]), 64'(t));
    chk($sformatf("%s.dest%0d", nm, k), 64'(cmt_dest[7*k +: 7]), 64'(d));
    chk($sformatf("%s.value%0d", nm, k), 64'(cmt_value[32*k +: 32]), 64'(v));
  endtask

  task automatic idle();
    disp_valid = 1'b0; disp_type = 2'd0; disp_dest = 7'd0;
    wb_valid = 1'b0; wb_tag = 4'd0; wb_value = 32'd0; wb_addr = 7'd0;
    wb_mispredict = 1'b0; wb_target = 32'd0; rd_tag1 = 4'd0; rd_tag2 = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    @(negedge clk);
    idle();
    disp_valid = v.dv; disp_type = v.dt; disp_dest = v.dd;
    wb_valid = v.wv; wb_tag = v.wt; wb_value = v.wval; wb_addr = v.wa;
    rd_tag1 = v.rt; rd_tag2 = v.rt;
    #1;
    chk({nm, ".disp_ready"}, 64'(disp_ready), 64'(v.e_rdy));
    chk({nm, ".disp_tag"}, 64'(disp_tag), 64'(v.e_tag));
    chk({nm, ".count"}, 64'(count), 64'(v.e_cnt));
    chk({nm, ".full"}, 64'(full), 64'(v.e_cnt == 5'd16));
    chk({nm, ".flush"}, 64'(flush), 64'd0);
    chk({nm, ".cmt_valid"}, 64'(cmt_valid), 64'(v.e_cv));
    for (int k = 0; k < CW; k++)
      if (v.e_cv[k]) chk_slot(nm, k, v.e_ctype[2*k +: 2], v.e_cdest[7*k +: 7], v.e_cval[32*k +: 32]);
    chk({nm, ".rd_ready1"}, 64'(rd_ready1), 64'(v.e_rr));
    chk({nm, ".rd_ready2"}, 64'(rd_ready2), 64'(v.e_rr));
    if (v.e_rr) begin
      chk({nm, ".rd_value1"}, 64'(rd_value1), 64'(v.e_rv));
      chk({nm, ".rd_value2"}, 64'(rd_value2), 64'(v.e_rv));
    end
    @(posedge clk);
  endtask

  task automatic mlook(input logic [3:0] t, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (mq[k]) begin
      if (mq[k].tag == t) begin
        if (wb_valid && wb_tag == t) begin r = 1'b1; v = wb_value; end
        else if (mq[k].rdy) begin r = 1'b1; v = mq[k].val; end
      end
    end
  endtask

  vec_t ta[4];
  vec_t tb[7];
  int   wb_order[8];
  int   n;
  logic fl, exp_dr, rr;
  logic [31:0] fpc, rv;
  mrec_t rec;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Full ROB of ALU ops dest 1..16: write tag1 then tag0, pair retires together.
    ta[0] = '{1'b0,2'd0,7'd0, 1'b1,4'd1,32'hA,7'd0, 4'd1, 1'b0,4'd0,5'd16, 2'b00,4'h0,14'h0,64'h0, 1'b1,32'hA};
    ta[1] = '{1'b0,2'd0,7'd0, 1'b1,4'd0,32'hB,7'd0, 4'd1, 1'b0,4'd0,5'd16, 2'b00,4'h0,14'h0,64'h0, 1'b1,32'hA};
    ta[2] = '{1'b0,2'd0,7'd0, 1'b0,4'd0,32'h0,7'd0, 4'd0, 1'b0,4'd0,5'd16, 2'b11,4'h0,14'h101,64'h0000000A_0000000B, 1'b1,32'hB};
    ta[3] = '{1'b0,2'd0,7'd0, 1'b0,4'd0,32'h0,7'd0, 4'd0, 1'b1,4'd0,5'd14, 2'b00,4'h0,14'h0,64'h0, 1'b0,32'h0};
    // STORE then ALU, both ready: store retires alone, ALU the cycle after.
    tb[0] = '{1'b1,2'd2,7'd5, 1'b0,4'd0,32'h0,7'd0, 4'd0, 1'b1,4'd0,5'd0, 2'b00,4'h0,14'h0,64'h0, 1'b0,32'h0};
    tb[1] = '{1'b1,2'd0,7'd6, 1'b0,4'd0,32'h0,7'd0, 4'd0, 1'b1,4'd1,5'd1, 2'b00,4'h0,14'h0,64'h0, 1'b0,32'h0};
    tb[2] = '{1'b0,2'd0,7'd0, 1'b1,4'd1,32'h66,7'd0, 4'd1, 1'b1,4'd2,5'd2, 2'b00,4'h0,14'h0,64'h0, 1'b1,32'h66};
    tb[3] = '{1'b0,2'd0,7'd0, 1'b1,4'd0,32'h55,7'h33, 4'd0, 1'b1,4'd2,5'd2, 2'b00,4'h0,14'h0,64'h0, 1'b1,32'h55};
    tb[4] = '{1'b0,2'd0,7'd0, 1'b0,4'd0,32'h0,7'd0, 4'd1, 1'b1,4'd2,5'd2, 2'b01,4'h2,14'h033,64'h55, 1'b1,32'h66};
    tb[5] = '{1'b0,2'd0,7'd0, 1'b0,4'd0,32'h0,7'd0, 4'd1, 1'b1,4'd2,5'd1, 2'b01,4'h0,14'h006,64'h66, 1'b1,32'h66};
    tb[6] = '{1'b0,2'd0,7'd0, 1'b0,4'd0,32'h0,7'd0, 4'd1, 1'b1,4'd2,5'd0, 2'b00,4'h0,14'h0,64'h0, 1'b0,32'h0};
    wb_order = '{3, 4, 5, 6, 7, 1, 2, 0};

    idle();
    #1 rst = 1'b0;
    #2;
    chk("rst.disp_ready", 64'(disp_ready), 64'd1);
    chk("rst.disp_tag", 64'(disp_tag), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.full", 64'(full), 64'd0);
    chk("rst.cmt_valid", 64'(cmt_valid), 64'd0);
    chk("rst.cmt_value", cmt_value, 64'd0);
    chk("rst.flush", 64'(flush), 64'd0);
    chk("rst.flush_pc", 64'(flush_pc), 64'd0);
    chk("rst.rd_ready1", 64'(rd_ready1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle();
      disp_valid = 1'b1; disp_dest = 7'(i + 1);
      #1;
      chk("fill.disp_tag", 64'(disp_tag), 64'(i));
      chk("fill.disp_ready", 64'(disp_ready), 64'd1);
      @(posedge clk);
    end
    @(negedge clk);
    idle();
    disp_valid = 1'b1; disp_dest = 7'd99;
    #1;
    chk("full.full", 64'(full), 64'd1);
    chk("full.disp_ready", 64'(disp_ready), 64'd0);
    chk("full.count", 64'(count), 64'd16);
    chk("full.cmt_valid", 64'(cmt_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    chk("full.count_after_reject", 64'(count), 64'd16);
    @(posedge clk);

    for (int i = 0; i < 4; i++) apply_vec(ta[i], $sformatf("pair%0d", i));

    // Reset with a commit pending must kill it without waiting for a clock edge.
    @(negedge clk);
    idle();
    wb_valid = 1'b1; wb_tag = 4'd2; wb_value = 32'h77;
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    chk("midrst.pre_cmt", 64'(cmt_valid), 64'd1);
    chk("midrst.pre_value", 64'(cmt_value[31:0]), 64'h77);
    rst = 1'b0;
    #1;
    chk("midrst.cmt_valid", 64'(cmt_valid), 64'd0);
    chk("midrst.count", 64'(count), 64'd0);
    chk("midrst.disp_ready", 64'(disp_ready), 64'd1);
    chk("midrst.disp_tag", 64'(disp_tag), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 7; i++) apply_vec(tb[i], $sformatf("store%0d", i));

    // Branch at tag 3 mispredicts with younger tags 4..7 already complete.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      idle();
      disp_valid = 1'b1; disp_type = (k == 3) ? T_BR : 2'd0; disp_dest = 7'(20 + k);
      #1;
      chk("br.disp_tag", 64'(disp_tag), 64'(k));
      @(posedge clk);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      idle();
      wb_valid = 1'b1; wb_tag = 4'(wb_order[j]);
      wb_value = (wb_order[j] == 5) ? 32'h1234 : 32'h100 + 32'(wb_order[j]);
      wb_mispredict = (wb_order[j] == 3); wb_target = 32'h40;
      rd_tag1 = 4'd5; rd_tag2 = 4'd4;
      #1;
      chk("br.wb_cmt_valid", 64'(cmt_valid), 64'd0);
      if (wb_order[j] == 5) begin
        chk("bypass.rd_ready1", 64'(rd_ready1), 64'd1);
        chk("bypass.rd_value1", 64'(rd_value1), 64'h1234);
        chk("bypass.rd_ready2", 64'(rd_ready2), 64'd1);
        chk("bypass.rd_value2", 64'(rd_value2), 64'h104);
      end
      @(posedge clk);
    end
    @(negedge clk);
    idle();
    #1;
    chk("br.c1.cmt_valid", 64'(cmt_valid), 64'd3);
    chk("br.c1.flush", 64'(flush), 64'd0);
    chk("br.c1.count", 64'(count), 64'd8);
    chk_slot("br.c1", 0, 2'd0, 7'd20, 32'h100);
    chk_slot("br.c1", 1, 2'd0, 7'd21, 32'h101);
    @(posedge clk);
    @(negedge clk);
    idle();
    disp_valid = 1'b1; disp_dest = 7'd9;
    wb_valid = 1'b1; wb_tag = 4'd5; wb_value = 32'hDEAD;
    #1;
    chk("br.c2.cmt_valid", 64'(cmt_valid), 64'd3);
    chk("br.c2.flush", 64'(flush), 64'd1);
    chk("br.c2.flush_pc", 64'(flush_pc), 64'h40);
    chk("br.c2.disp_ready", 64'(disp_ready), 64'd0);
    chk("br.c2.count", 64'(count), 64'd6);
    chk_slot("br.c2", 0, 2'd0, 7'd22, 32'h102);
    chk_slot("br.c2", 1, T_BR, 7'd23, 32'h103);
    @(posedge clk);
    @(negedge clk);
    idle();
    rd_tag1 = 4'd5;
    #1;
    chk("br.c3.count", 64'(count), 64'd0);
    chk("br.c3.disp_tag", 64'(disp_tag), 64'd4);
    chk("br.c3.cmt_valid", 64'(cmt_valid), 64'd0);
    chk("br.c3.flush", 64'(flush), 64'd0);
    chk("br.c3.disp_ready", 64'(disp_ready), 64'd1);
    chk("br.c3.rd_ready1", 64'(rd_ready1), 64'd0);
    disp_valid = 1'b1; disp_dest = 7'd11;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      #1;
      chk("br.after.cmt_valid", 64'(cmt_valid), 64'd0);
      chk("br.after.count", 64'(count), 64'd1);
      @(posedge clk);
    end

    // Random traffic against a program-order queue model.
    do_reset();
    mq.delete();
    m_tail = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rst = 1'b1;
      idle();
      disp_valid = ($urandom_range(0, 99) < 60);
      disp_type = 2'($urandom_range(0, 3));
      disp_dest = 7'($urandom);
      wb_valid = ($urandom_range(0, 99) < (((cyc % 200) < 100) ? 25 : 80));
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) wb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else wb_tag = 4'($urandom);
      wb_value = $urandom; wb_addr = 7'($urandom);
      wb_mispredict = ($urandom_range(0, 5) == 0); wb_target = $urandom;
      rd_tag1 = 4'($urandom); rd_tag2 = 4'($urandom);
      if (cyc == 700) begin
        rst = 1'b0;
        #1;
        chk("rnd.rst.cmt_valid", 64'(cmt_valid), 64'd0);
        chk("rnd.rst.count", 64'(count), 64'd0);
        chk("rnd.rst.disp_ready", 64'(disp_ready), 64'd1);
        mq.delete();
        m_tail = 0;
        @(posedge clk);
        continue;
      end
      #1;
      n = 0; fl = 1'b0; fpc = 32'd0;
      while (n < CW && n < mq.size() && mq[n].rdy) begin
        n++;
        if (mq[n-1].typ == T_ST) break;
        if (mq[n-1].typ == T_BR && mq[n-1].mis) begin fl = 1'b1; fpc = mq[n-1].tgt; break; end
      end
      exp_dr = (mq.size() < DEPTH) && !fl;
      chk("rnd.count", 64'(count), 64'(mq.size()));
      chk("rnd.full", 64'(full), 64'(mq.size() == DEPTH));
      chk("rnd.disp_ready", 64'(disp_ready), 64'(exp_dr));
      chk("rnd.disp_tag", 64'(disp_tag), 64'(m_tail));
      chk("rnd.cmt_valid", 64'(cmt_valid), 64'((1 << n) - 1));
      for (int k = 0; k < n; k++) chk_slot("rnd", k, mq[k].typ, mq[k].dest, mq[k].val);
      chk("rnd.flush", 64'(flush), 64'(fl));
      if (fl) chk("rnd.flush_pc", 64'(flush_pc), 64'(fpc));
      mlook(rd_tag1, rr, rv);
      chk("rnd.rd_ready1", 64'(rd_ready1), 64'(rr));
      if (rr) chk("rnd.rd_value1", 64'(rd_value1), 64'(rv));
      mlook(rd_tag2, rr, rv);
      chk("rnd.rd_ready2", 64'(rd_ready2), 64'(rr));
      if (rr) chk("rnd.rd_value2", 64'(rd_value2), 64'(rv));
      @(posedge clk);
      if (fl) begin
        m_tail = (int'(mq[n-1].tag) + 1) % DEPTH;
        mq.delete();
      end else begin
        if (wb_valid) begin
          foreach (mq[k]) begin
            if (mq[k].tag == wb_tag) begin
              rec = mq[k];
              rec.rdy = 1'b1;
              rec.val = wb_value;
              if (rec.typ == T_ST) rec.dest = wb_addr;
              if (rec.typ == T_BR) begin rec.mis = wb_mispredict; rec.tgt = wb_target; end
              mq[k] = rec;
            end
          end
        end
        repeat (n) void'(mq.pop_front());
        if (disp_valid && exp_dr) begin
          rec.tag = 4'(m_tail); rec.typ = disp_type; rec.dest = disp_dest;
          rec.rdy = 1'b0; rec.val = 32'd0; rec.mis = 1'b0; rec.tgt = 32'd0;
          mq.push_back(rec);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
